hamming_secded_rx: RTL and testbench

Serial receive-side SECDED decoder for the Hamming link. Consumes the bit-serial Hamming(8,4) codeword stream produced by the serial encoder stage. Each codeword is 7 Hamming bits plus an overall parity bit. The block deserializes it, corrects any single-bit error, flags double-bit errors, and presents a 4-bit parallel nibble with a one-cycle valid pulse. It also keeps saturating error statistics for link monitoring.

---
 rtl/hamming_pkg.sv | 39 +++
 rtl/hamming_secded_dec_core.sv | 48 ++++
 rtl/hamming_secded_rx.sv | 131 +++++++++++++
 tb/tb_hamming_secded_rx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming(8,4) SECDED definitions for the encoder and decoder stages.
// Codeword vectors are indexed so that cw[i-1] holds bit c_i.
package hamming_pkg;

    localparam int CW_BITS   = 8;
    localparam int DATA_BITS = 4;

    localparam int POS_P1 = 1;
    localparam int POS_P2 = 2;
    localparam int POS_D1 = 3;
    localparam int POS_P4 = 4;
    localparam int POS_D2 = 5;
    localparam int POS_D3 = 6;
    localparam int POS_D4 = 7;
    localparam int POS_P0 = 8;

    typedef enum logic [1:0] {
        CLEAN   = 2'd0,
        CORR    = 2'd1,
        CORR_P0 = 2'd2,
        UNCORR  = 2'd3
    } dec_class_e;

    // data is {d4,d3,d2,d1}
    function automatic logic [CW_BITS-1:0] hamming_encode(input logic [DATA_BITS-1:0] data);
        logic [CW_BITS-1:0] cw;
        cw = '0;
        cw[POS_D1-1] = data[0];
        cw[POS_D2-1] = data[1];
        cw[POS_D3-1] = data[2];
        cw[POS_D4-1] = data[3];
        cw[POS_P1-1] = data[0] ^ data[1] ^ data[3];
        cw[POS_P2-1] = data[0] ^ data[2] ^ data[3];
        cw[POS_P4-1] = data[1] ^ data[2] ^ data[3];
        cw[POS_P0-1] = ^cw[POS_D4-1:0];
        return cw;
    endfunction

endpackage

// File: rtl/hamming_secded_dec_core.sv
// Combinational SECDED decode of one 8-bit codeword: syndrome, overall parity,
// classification and single-bit correction.
module hamming_secded_dec_core
    import hamming_pkg::*;
(
    input  logic [CW_BITS-1:0]   cw,
    output logic [DATA_BITS-1:0] data,
    output dec_class_e           dec_class,
    output logic [2:0]           err_pos
);

    logic [2:0]         syn;
    logic               q;
    logic [CW_BITS-1:0] fixed;

    // Syndrome bit k covers every Hamming position whose index has bit k set.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_syn
            always_comb begin
                syn[gi] = 1'b0;
                for (int i = 1; i <= POS_D4; i++) begin
                    if (((i >> gi) & 1) == 1)
                        syn[gi] = syn[gi] ^ cw[i-1];
                end
            end
        end
    endgenerate

    assign q = ^cw;

    always_comb begin
        fixed     = cw;
        dec_class = CLEAN;
        err_pos   = 3'd0;
        if (syn != 3'd0 && q) begin
            dec_class          = CORR;
            err_pos            = syn;
            fixed[syn - 3'd1]  = ~cw[syn - 3'd1];
        end else if (syn == 3'd0 && q) begin
            dec_class = CORR_P0;
        end else if (syn != 3'd0 && !q) begin
            dec_class = UNCORR;
        end
    end

    assign data = {fixed[POS_D4-1], fixed[POS_D3-1], fixed[POS_D2-1], fixed[POS_D1-1]};

endmodule

// File: rtl/hamming_secded_rx.sv
// Serial SECDED receiver: deserializes c1..c8, decodes on the c8 write and
// registers the nibble, flags and saturating error counters.
module hamming_secded_rx
    import hamming_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 write,
    input  logic                 frame_clr,
    input  logic                 cnt_clr,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 err_corrected,
    output logic                 err_uncorrectable,
    output logic [2:0]           err_pos,
    output logic [CNT_W-1:0]     corr_cnt,
    output logic [CNT_W-1:0]     uncorr_cnt
);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e                 state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [CW_BITS-2:0]     sr_q, sr_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   corr_q, corr_d;
    logic                   uncorr_q, uncorr_d;
    logic [2:0]             pos_q, pos_d;
    logic [CNT_W-1:0]       corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0]       uncorr_cnt_q, uncorr_cnt_d;

    logic [DATA_BITS-1:0]   dec_data;
    dec_class_e             dec_class;
    logic [2:0]             dec_pos;
    logic                   fire;

    // New bits enter at the top, so after c7 the register holds c7..c1 and
    // the incoming bit completes the codeword as c8.
    hamming_secded_dec_core u_core (
        .cw        ({serial_in, sr_q}),
        .data      (dec_data),
        .dec_class (dec_class),
        .err_pos   (dec_pos)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        sr_d         = sr_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        corr_d       = corr_q;
        uncorr_d     = uncorr_q;
        pos_d        = pos_q;
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        fire         = 1'b0;

        if (frame_clr) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
        end else if (write) begin
            if (state_q == SHIFT && bit_cnt_q == 3'd7) begin
                fire      = 1'b1;
                state_d   = IDLE;
                bit_cnt_d = 3'd0;
            end else begin
                state_d   = SHIFT;
                bit_cnt_d = bit_cnt_q + 3'd1;
                sr_d      = {serial_in, sr_q[CW_BITS-2:1]};
            end
        end

        if (fire) begin
            valid_d  = 1'b1;
            data_d   = dec_data;
            corr_d   = (dec_class == CORR) || (dec_class == CORR_P0);
            uncorr_d = (dec_class == UNCORR);
            pos_d    = dec_pos;
        end

        if (cnt_clr) begin
            corr_cnt_d   = '0;
            uncorr_cnt_d = '0;
        end else if (fire) begin
            if (corr_d && corr_cnt_q != {CNT_W{1'b1}})
                corr_cnt_d = corr_cnt_q + 1'b1;
            if (uncorr_d && uncorr_cnt_q != {CNT_W{1'b1}})
                uncorr_cnt_d = uncorr_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= 3'd0;
            sr_q         <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            corr_q       <= 1'b0;
            uncorr_q     <= 1'b0;
            pos_q        <= 3'd0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            sr_q         <= sr_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            corr_q       <= corr_d;
            uncorr_q     <= uncorr_d;
            pos_q        <= pos_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
        end
    end

    assign data_out          = data_q;
    assign data_valid        = valid_q;
    assign err_corrected     = corr_q;
    assign err_uncorrectable = uncorr_q;
    assign err_pos           = pos_q;
    assign corr_cnt          = corr_cnt_q;
    assign uncorr_cnt        = uncorr_cnt_q;

endmodule

// File: tb/tb_hamming_secded_rx.sv
// Directed bench for hamming_secded_rx with CNT_W=2 so saturation is reachable.
module tb_hamming_secded_rx;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             serial_in = 1'b0;
    logic             write = 1'b0;
    logic             frame_clr = 1'b0;
    logic             cnt_clr = 1'b0;
    logic [3:0]       data_out;
    logic             data_valid;
    logic             err_corrected;
    logic             err_uncorrectable;
    logic [2:0]       err_pos;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] uncorr_cnt;

    int total = 0;
    int bad = 0;
    int valid_seen = 0;

    hamming_secded_rx #(.CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .serial_in         (serial_in),
        .write             (write),
        .frame_clr         (frame_clr),
        .cnt_clr           (cnt_clr),
        .data_out          (data_out),
        .data_valid        (data_valid),
        .err_corrected     (err_corrected),
        .err_uncorrectable (err_uncorrectable),
        .err_pos           (err_pos),
        .corr_cnt          (corr_cnt),
        .uncorr_cnt        (uncorr_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (data_valid) valid_seen++;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // bits are c1..c8 read left to right; returns on the negedge where
    // data_valid should be high, leaving write asserted for the caller.
    task automatic send(input logic [7:0] bits, input bit gaps, input bit clr_last);
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                for (int g = 0; g < (i * 5 + 1) % 3; g++) begin
                    write = 1'b0;
                    serial_in = ~bits[7-i];
                    @(negedge clk);
                end
            end
            write = 1'b1;
            serial_in = bits[7-i];
            cnt_clr = clr_last && (i == 7);
            @(negedge clk);
        end
        cnt_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        write = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int v0;
        do_reset();
        check("reset data_out", data_out, 0);
        check("reset valid", data_valid, 0);
        check("reset corr_cnt", corr_cnt, 0);
        check("reset uncorr_cnt", uncorr_cnt, 0);

        // nibble 1011 clean
        send(8'b10101010, 0, 0);
        write = 1'b0;
        check("clean valid", data_valid, 1);
        check("clean data", data_out, 4'b1011);
        check("clean corr", err_corrected, 0);
        check("clean uncorr", err_uncorrectable, 0);
        check("clean corr_cnt", corr_cnt, 0);
        @(negedge clk);
        check("clean valid drops", data_valid, 0);
        check("clean data held", data_out, 4'b1011);
        idle(2);

        // c5 flipped
        send(8'b10100010, 0, 0);
        write = 1'b0;
        check("c5 valid", data_valid, 1);
        check("c5 data", data_out, 4'b1011);
        check("c5 corr", err_corrected, 1);
        check("c5 pos", err_pos, 5);
        check("c5 corr_cnt", corr_cnt, 1);
        idle(1);

        // c8 flipped
        send(8'b10101011, 0, 0);
        write = 1'b0;
        check("p0 data", data_out, 4'b1011);
        check("p0 corr", err_corrected, 1);
        check("p0 pos", err_pos, 0);
        check("p0 corr_cnt", corr_cnt, 2);
        idle(1);

        // c3 and c6 flipped: raw data bits pass through
        send(8'b10001110, 0, 0);
        write = 1'b0;
        check("dbl uncorr", err_uncorrectable, 1);
        check("dbl corr", err_corrected, 0);
        check("dbl pos", err_pos, 0);
        check("dbl data", data_out, 4'b1110);
        check("dbl uncorr_cnt", uncorr_cnt, 1);
        check("dbl corr_cnt", corr_cnt, 2);
        idle(1);

        // gaps inside frames: nibble 0110 clean, then c7 flipped
        send(8'b11001100, 1, 0);
        write = 1'b0;
        check("gap clean valid", data_valid, 1);
        check("gap clean data", data_out, 4'b0110);
        check("gap clean corr", err_corrected, 0);
        idle(1);
        send(8'b11001110, 1, 0);
        write = 1'b0;
        check("gap c7 data", data_out, 4'b0110);
        check("gap c7 pos", err_pos, 7);
        check("gap c7 corr_cnt", corr_cnt, 3);
        idle(1);

        // abort after 3 bits, then one full frame
        v0 = valid_seen;
        write = 1'b1; serial_in = 1'b1; @(negedge clk);
        serial_in = 1'b0; @(negedge clk);
        serial_in = 1'b1; @(negedge clk);
        frame_clr = 1'b1; serial_in = 1'b0; @(negedge clk);
        frame_clr = 1'b0;
        idle(1);
        send(8'b10101010, 0, 0);
        write = 1'b0;
        idle(2);
        check("abort one valid", valid_seen - v0, 1);
        check("abort data", data_out, 4'b1011);
        check("abort corr", err_corrected, 0);

        // back-to-back frames, no bubble
        send(8'b11001100, 0, 0);
        check("b2b first data", data_out, 4'b0110);
        send(8'b10100010, 0, 0);
        write = 1'b0;
        check("b2b second valid", data_valid, 1);
        check("b2b second data", data_out, 4'b1011);
        check("b2b second pos", err_pos, 5);
        idle(1);

        // asynchronous reset mid-frame
        write = 1'b1;
        for (int i = 0; i < 4; i++) begin
            serial_in = i[0];
            @(negedge clk);
        end
        write = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst data_out", data_out, 0);
        check("rst pos", err_pos, 0);
        check("rst corr_cnt", corr_cnt, 0);
        check("rst uncorr_cnt", uncorr_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(8'b11001100, 0, 0);
        write = 1'b0;
        check("post-rst valid", data_valid, 1);
        check("post-rst data", data_out, 4'b0110);
        idle(1);

        // saturation then clear priority
        for (int f = 1; f <= 5; f++) begin
            send(8'b10100010, 0, 0);
            check($sformatf("sat frame%0d", f), corr_cnt, (f > 3) ? 3 : f);
        end
        send(8'b10100010, 0, 1);
        write = 1'b0;
        check("clr wins valid", data_valid, 1);
        check("clr wins corr_cnt", corr_cnt, 0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
